// File: rtl/sobel_pipe.sv
// Two-stage pipelined Sobel edge core producing NUM_CORES pixels per beat with valid/ready flow control.
// Define SOBEL_THRESHOLD_EN to add the thresh port and binarise the output.
module sobel_pipe #(
  parameter int NUM_CORES = 8,
  parameter int PIX_W     = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [(NUM_CORES+2)*PIX_W-1:0]  row1_data,
  input  logic [(NUM_CORES+2)*PIX_W-1:0]  row2_data,
  input  logic [(NUM_CORES+2)*PIX_W-1:0]  row3_data,
  input  logic                            sat_mode,
`ifdef SOBEL_THRESHOLD_EN
  input  logic [PIX_W-1:0]                thresh,
`endif
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_CORES*PIX_W-1:0]      out_data,
  input  logic                            cnt_clr,
  output logic [15:0]                     out_count
);

  localparam int GW = PIX_W + 4;
  localparam logic [GW-1:0] PIX_MAX = GW'((1 << PIX_W) - 1);

  logic                          en;
  logic [NUM_CORES-1:0][GW-1:0]  ax_d, ay_d;
  logic [NUM_CORES-1:0][GW-1:0]  s1_ax, s1_ay;
  logic                          s1_valid;
  logic                          s1_sat;
`ifdef SOBEL_THRESHOLD_EN
  logic [PIX_W-1:0]              s1_thresh;
`endif
  logic [NUM_CORES*PIX_W-1:0]    p_d;
  logic [GW-1:0]                 s_c;
  logic [PIX_W-1:0]              p_c;

  // Whole pipeline advances together; a held output stalls both stages.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    logic [PIX_W-1:0] r1l, r1m, r1r, r2l, r2r, r3l, r3m, r3r;
    logic [GW-1:0]    gx, gy;

    assign r1l = row1_data[(c+2)*PIX_W +: PIX_W];
    assign r1m = row1_data[(c+1)*PIX_W +: PIX_W];
    assign r1r = row1_data[c*PIX_W     +: PIX_W];
    assign r2l = row2_data[(c+2)*PIX_W +: PIX_W];
    assign r2r = row2_data[c*PIX_W     +: PIX_W];
    assign r3l = row3_data[(c+2)*PIX_W +: PIX_W];
    assign r3m = row3_data[(c+1)*PIX_W +: PIX_W];
    assign r3r = row3_data[c*PIX_W     +: PIX_W];

    // Two's complement in GW bits; magnitudes never exceed 4*(2^PIX_W-1).
    assign gx = (GW'(r1l) + (GW'(r1m) << 1) + GW'(r1r))
              - (GW'(r3l) + (GW'(r3m) << 1) + GW'(r3r));
    assign gy = (GW'(r1l) + (GW'(r2l) << 1) + GW'(r3l))
              - (GW'(r1r) + (GW'(r2r) << 1) + GW'(r3r));

    assign ax_d[c] = gx[GW-1] ? -gx : gx;
    assign ay_d[c] = gy[GW-1] ? -gy : gy;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_sat    <= 1'b0;
      s1_ax     <= '0;
      s1_ay     <= '0;
`ifdef SOBEL_THRESHOLD_EN
      s1_thresh <= '0;
`endif
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_sat    <= sat_mode;
      s1_ax     <= ax_d;
      s1_ay     <= ay_d;
`ifdef SOBEL_THRESHOLD_EN
      s1_thresh <= thresh;
`endif
    end
  end

  always_comb begin
    p_d = '0;
    s_c = '0;
    p_c = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      s_c = s1_ax[c] + s1_ay[c];
      if (s1_sat && (s_c > PIX_MAX)) begin
        p_c = '1;
      end else begin
        p_c = s_c[PIX_W-1:0];
      end
`ifdef SOBEL_THRESHOLD_EN
      p_c = (p_c >= s1_thresh) ? '1 : '0;
`endif
      p_d[c*PIX_W +: PIX_W] = p_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_data  <= p_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_count <= '0;
    end else if (cnt_clr) begin
      out_count <= '0;
    end else if (out_valid && out_ready) begin
      out_count <= out_count + 16'd1;
    end
  end

endmodule
